// File: rtl/muladd_arb_pkg.sv
// Shared types and helpers for the arbitrated multiply-add pipeline.
package muladd_arb_pkg;

    localparam int MaxX  = 32;
    localparam int MaxY  = 32;
    localparam int MaxA  = 64;
    localparam int MaxId = 4;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Fields are sized for the widest legal configuration.
    typedef struct packed {
        logic            valid;
        logic [MaxX-1:0] x;
        logic [MaxY-1:0] y;
        logic [MaxA-1:0] a;
        logic [MaxId-1:0] id;
    } stage_t;

endpackage

// File: rtl/MulAddUns.sv
// Unsigned P = X*Y + A, truncated to widthA bits.
module MulAddUns #(
    parameter int widthX = 8,
    parameter int widthY = 8,
    parameter int widthA = 20,
    parameter int speed  = 0
) (
    input  logic [widthX-1:0] x,
    input  logic [widthY-1:0] y,
    input  logic [widthA-1:0] a,
    output logic [widthA-1:0] p
);

    assign p = widthA'(x) * widthA'(y) + a;

endmodule

// File: rtl/muladd_rr_arb.sv
// Round-robin arbiter; pointer holds the last granted index.
module muladd_rr_arb
    import muladd_arb_pkg::*;
#(
    parameter  int NumReq = 4,
    localparam int IdW    = id_width(NumReq)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NumReq-1:0] valid,
    input  logic              advance,
    output logic [NumReq-1:0] grant,
    output logic [IdW-1:0]    grant_id
);

    logic [IdW-1:0] ptr;
    logic [IdW-1:0] hi_sel;
    logic [IdW-1:0] lo_sel;
    logic           hi_any;
    logic           lo_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IdW'(NumReq - 1);
        end else if (advance) begin
            ptr <= grant_id;
        end
    end

    // Lowest valid index above ptr wins, else lowest valid overall.
    always_comb begin
        hi_sel = '0;
        lo_sel = '0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (valid[i]) begin
                lo_sel = IdW'(i);
                lo_any = 1'b1;
                if (IdW'(i) > ptr) begin
                    hi_sel = IdW'(i);
                    hi_any = 1'b1;
                end
            end
        end
        grant_id = hi_any ? hi_sel : lo_sel;
        grant    = '0;
        if (lo_any) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/muladd_arb.sv
// Round-robin arbitrated two-stage multiply-add pipeline.
module muladd_arb
    import muladd_arb_pkg::*;
#(
    parameter int NumReq = 4,
    parameter int widthX = 8,
    parameter int widthY = 8,
    parameter int widthA = 20,
    parameter int speed  = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumReq-1:0]          req_valid_i,
    output logic [NumReq-1:0]          req_ready_o,
    input  logic [NumReq*widthX-1:0]   req_x_i,
    input  logic [NumReq*widthY-1:0]   req_y_i,
    input  logic [NumReq*widthA-1:0]   req_a_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [widthA-1:0]          res_p_o,
    output logic [id_width(NumReq)-1:0] res_id_o,
    output logic                       busy_o
);

    localparam int IdW = id_width(NumReq);

    stage_t              s1;
    logic                s2_valid;
    logic [widthA-1:0]   s2_p;
    logic [IdW-1:0]      s2_id;
    logic [widthA-1:0]   p;
    logic [NumReq-1:0]   grant;
    logic [IdW-1:0]      grant_id;
    logic                s1_open;
    logic                s2_open;
    logic                accept;
    logic [widthX-1:0]   op_x;
    logic [widthY-1:0]   op_y;
    logic [widthA-1:0]   op_a;
    logic                unused_s1;

    assign s2_open     = !s2_valid || res_ready_i;
    assign s1_open     = !s1.valid || s2_open;
    assign req_ready_o = (rst_i || !s1_open) ? '0 : grant;
    assign accept      = |req_ready_o;

    muladd_rr_arb #(
        .NumReq(NumReq)
    ) u_arb (
        .clk     (clk_i),
        .rst     (rst_i),
        .valid   (req_valid_i),
        .advance (accept),
        .grant   (grant),
        .grant_id(grant_id)
    );

    always_comb begin
        op_x = '0;
        op_y = '0;
        op_a = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (grant[k]) begin
                op_x = req_x_i[k*widthX +: widthX];
                op_y = req_y_i[k*widthY +: widthY];
                op_a = req_a_i[k*widthA +: widthA];
            end
        end
    end

    MulAddUns #(
        .widthX(widthX),
        .widthY(widthY),
        .widthA(widthA),
        .speed (speed)
    ) u_muladd (
        .x(s1.x[widthX-1:0]),
        .y(s1.y[widthY-1:0]),
        .a(s1.a[widthA-1:0]),
        .p(p)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1       <= '0;
            s2_valid <= 1'b0;
            s2_p     <= '0;
            s2_id    <= '0;
        end else begin
            if (s1_open) begin
                s1.valid <= accept;
                if (accept) begin
                    s1.x  <= MaxX'(op_x);
                    s1.y  <= MaxY'(op_y);
                    s1.a  <= MaxA'(op_a);
                    s1.id <= MaxId'(grant_id);
                end
            end
            if (s2_open) begin
                s2_valid <= s1.valid;
                if (s1.valid) begin
                    s2_p  <= p;
                    s2_id <= s1.id[IdW-1:0];
                end
            end
        end
    end

    // Upper struct bits beyond the configured widths stay zero.
    assign unused_s1 = ^{s1.x, s1.y, s1.a, s1.id};

    assign res_valid_o = s2_valid;
    assign res_p_o     = s2_p;
    assign res_id_o    = s2_id;
    assign busy_o      = s1.valid || s2_valid;

endmodule

// File: tb/tb_muladd_arb.sv
// Scoreboard bench for muladd_arb with default parameters.
module tb_muladd_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  ready;
    logic [31:0] x_bus;
    logic [31:0] y_bus;
    logic [79:0] a_bus;
    logic        res_valid;
    logic        res_ready;
    logic [19:0] res_p;
    logic [1:0]  res_id;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [21:0] q[$];

    logic        prev_stall = 1'b0;
    logic [19:0] prev_p;
    logic [1:0]  prev_id;

    always #5 clk = ~clk;

    muladd_arb dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(valid),
        .req_ready_o(ready),
        .req_x_i    (x_bus),
        .req_y_i    (y_bus),
        .req_a_i    (a_bus),
        .res_valid_o(res_valid),
        .res_ready_i(res_ready),
        .res_p_o    (res_p),
        .res_id_o   (res_id),
        .busy_o     (busy)
    );

    function automatic logic [19:0] model(logic [7:0] x, logic [7:0] y,
                                          logic [19:0] a);
        logic [31:0] t;
        t = 32'(x) * 32'(y) + 32'(a);
        return t[19:0];
    endfunction

    // Scoreboard: pop on result transfer, push on accepted request.
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra got id=%0d p=%h required none",
                         res_id, res_p);
            end else begin
                logic [21:0] e;
                e = q.pop_front();
                if ({res_id, res_p} !== e) begin
                    bad++;
                    $display("FAIL sb_result got id=%0d p=%h required id=%0d p=%h",
                             res_id, res_p, e[21:20], e[19:0]);
                end
            end
        end
        if (prev_stall) begin
            total++;
            if (!res_valid || res_p !== prev_p || res_id !== prev_id) begin
                bad++;
                $display("FAIL stall_hold got v=%b id=%0d p=%h required v=1 id=%0d p=%h",
                         res_valid, res_id, res_p, prev_id, prev_p);
            end
        end
        if (ready != 4'b0) begin
            total++;
            if ($countones(ready) != 1 || (ready & ~valid) != 4'b0) begin
                bad++;
                $display("FAIL ready_onehot got ready=%b valid=%b", ready, valid);
            end
        end
        prev_stall = res_valid && !res_ready && !rst;
        prev_p     = res_p;
        prev_id    = res_id;
        if (rst) begin
            q.delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (valid[k] && ready[k]) begin
                    q.push_back({2'(k), model(x_bus[k*8 +: 8], y_bus[k*8 +: 8],
                                              a_bus[k*20 +: 20])});
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(int k, logic [7:0] x, logic [7:0] y, logic [19:0] a);
        x_bus[k*8 +: 8]   = x;
        y_bus[k*8 +: 8]   = y;
        a_bus[k*20 +: 20] = a;
    endtask

    task automatic drain;
        int n;
        n = 0;
        valid = 4'b0;
        res_ready = 1'b1;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || q.size() != 0) begin
            bad++;
            $display("FAIL drain got busy=%b pending=%0d required busy=0 pending=0",
                     busy, q.size());
        end
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        valid = 4'b1111;
        res_ready = 1'b1;
        x_bus = '0;
        y_bus = '0;
        a_bus = '0;
        tick();
        @(negedge clk);
        total++;
        if (ready !== 4'b0) begin
            bad++;
            $display("FAIL reset_ready got %b required 0000", ready);
        end
        tick();
        valid = 4'b0;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({res_valid, busy, res_p, res_id, ready} !== '0) begin
            bad++;
            $display("FAIL reset_state got v=%b busy=%b p=%h id=%0d ready=%b required zeros",
                     res_valid, busy, res_p, res_id, ready);
        end
        tick();
    endtask

    task automatic test_single;
        set_op(2, 8'd255, 8'd255, 20'h0);
        valid = 4'b0100;
        @(negedge clk);
        total++;
        if (ready !== 4'b0100) begin
            bad++;
            $display("FAIL single_grant got %b required 0100", ready);
        end
        tick();
        valid = 4'b0;
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early got v=%b required 0", res_valid);
        end
        tick();
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_p !== 20'h0FE01 || res_id !== 2'd2) begin
            bad++;
            $display("FAIL single_result got v=%b p=%h id=%0d required v=1 p=0fe01 id=2",
                     res_valid, res_p, res_id);
        end
        tick();
    endtask

    task automatic test_wrap;
        set_op(1, 8'd1, 8'd1, 20'hFFFFF);
        valid = 4'b0010;
        tick();
        valid = 4'b0;
        tick();
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || res_p !== 20'h00000 || res_id !== 2'd1) begin
            bad++;
            $display("FAIL wrap got v=%b p=%h id=%0d required v=1 p=00000 id=1",
                     res_valid, res_p, res_id);
        end
        tick();
    endtask

    task automatic test_fairness;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) begin
                set_op(k, 8'(i * 16 + k + 3), 8'(200 - i * 7 - k), 20'(i * 1000 + k));
            end
            valid = 4'b1111;
            @(negedge clk);
            total++;
            if (ready !== 4'(1 << (i % 4))) begin
                bad++;
                $display("FAIL fair_grant%0d got %b required %b", i, ready,
                         4'(1 << (i % 4)));
            end
            if (i >= 2) begin
                total++;
                if (res_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL fair_thru%0d got v=%b required 1", i, res_valid);
                end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure;
        int acc;
        acc = 0;
        res_ready = 1'b0;
        valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 4; k++) begin
                set_op(k, 8'(i * 37 + k), 8'(i + 11 * k), 20'(i * 4096 + k));
            end
            @(negedge clk);
            acc += $countones(ready & valid);
            if (i == 5) begin
                total++;
                if (ready !== 4'b0) begin
                    bad++;
                    $display("FAIL bp_blocked got %b required 0000", ready);
                end
            end
            tick();
        end
        total++;
        if (acc != 2) begin
            bad++;
            $display("FAIL bp_accepts got %0d required 2", acc);
        end
        drain();
    endtask

    task automatic test_reset_mid;
        res_ready = 1'b0;
        valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            set_op(k, 8'(k + 5), 8'(k + 9), 20'(k));
        end
        tick();
        tick();
        @(negedge clk);
        total++;
        if (res_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_full got v=%b busy=%b required 1 1", res_valid, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (ready !== 4'b0) begin
            bad++;
            $display("FAIL mid_rst_ready got %b required 0000", ready);
        end
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || ready !== 4'b0001) begin
            bad++;
            $display("FAIL mid_after got v=%b busy=%b ready=%b required 0 0 0001",
                     res_valid, busy, ready);
        end
        tick();
        drain();
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) begin
                set_op(k, 8'($urandom), 8'($urandom), 20'($urandom));
            end
            valid = 4'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muladd_arb.md
MULADD_ARB -- requirements
Module: muladd_arb

Interface
REQ-001 SHALL have parameter NumReq, default 4, meaning the number of requesters (2..16).
REQ-002 SHALL have parameter widthX, default 8, meaning the multiplier width (<= widthY).
REQ-003 SHALL have parameter widthY, default 8, meaning the multiplicand width.
REQ-004 SHALL have parameter widthA, default 20, meaning the augend and result width (>= widthX+widthY).
REQ-005 SHALL have parameter speed, default 0, passed unchanged to the MulAddUns instance.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port req_valid_i, input, NumReq bits: per-requester operand valid.
REQ-009 SHALL have port req_ready_o, output, NumReq bits: per-requester accept.
REQ-010 SHALL have port req_x_i, input, NumReq*widthX bits: packed X, requester k at [k*widthX +: widthX].
REQ-011 SHALL have port req_y_i, input, NumReq*widthY bits: packed Y.
REQ-012 SHALL have port req_a_i, input, NumReq*widthA bits: packed A.
REQ-013 SHALL have port res_valid_o, output, 1 bit: result valid.
REQ-014 SHALL have port res_ready_i, input, 1 bit: result consumer ready.
REQ-015 SHALL have port res_p_o, output, widthA bits: P = (X*Y + A) mod 2^widthA.
REQ-016 SHALL have port res_id_o, output, $clog2(NumReq) bits: index of the requester that originated the result.
REQ-017 SHALL have port busy_o, output, 1 bit: high while any pipeline stage holds valid data.

Function
REQ-018 SHALL be a two-stage pipeline: S1 holds registered operands and id, feeds one shared MulAddUns; S2 holds registered P and id.
REQ-019 SHALL accept a handshake on requester k only in a cycle where req_valid_i[k] and req_ready_o[k] are both high.
REQ-020 SHALL raise at most one req_ready_o bit per cycle, and only for the round-robin winner among the valid requesters.
REQ-021 SHALL raise req_ready_o only when S1 is empty or S1 advances in the same cycle; req_ready_o may depend combinationally on req_valid_i.
REQ-022 SHALL search for the round-robin winner starting at (last granted index + 1) mod NumReq and SHALL update the pointer only on an accepted handshake.
REQ-023 SHALL advance S1 into S2 when S2 is empty or res_ready_i is high.
REQ-024 SHALL drive res_valid_o directly from the S2 valid flag and hold res_p_o and res_id_o stable while res_valid_o && !res_ready_i.
REQ-025 SHALL, without a stall, assert res_valid_o in the cycle two clock edges after the accepting cycle; sustained throughput SHALL be one result per cycle.
REQ-026 SHALL never drop, duplicate or reorder accepted operations; results leave in acceptance order.
REQ-027 SHALL wrap P modulo 2^widthA, with no overflow flag.
REQ-028 SHALL accept a new operation in a cycle where S2 drains and S1 advances (full pipeline with res_ready_i high).
REQ-029 SHALL keep all req_ready_o low and leave the pointer unchanged when no req_valid_i bit is high.

Reset
REQ-030 SHALL, while rst_i is high at a clock edge, clear S1/S2 valid flags, set the pointer so that requester 0 has highest priority, and discard in-flight operations.
REQ-031 SHALL hold res_valid_o=0, req_ready_o=0, busy_o=0, res_p_o=0 and res_id_o=0 in the cycle after reset, and req_ready_o=0 throughout reset.

Structure
REQ-032 SHALL place the id width function and the pipeline-stage struct typedef (valid, X, Y, A, id) in the shared package muladd_arb_pkg.
REQ-033 SHALL implement arbitration in the sub-module muladd_rr_arb (valid vector in, grant one-hot out, advance strobe) and instantiate MulAddUns exactly once.

Verification
REQ-034 SHALL cover: requester 2 alone sends X=255, Y=255, A=0 -> res_p_o=0x0FE01 and res_id_o=2 two cycles after acceptance.
REQ-035 SHALL cover wrap-around: X=1, Y=1, A=0xFFFFF -> res_p_o=0x00000.
REQ-036 SHALL cover fairness: all 4 requesters valid continuously with res_ready_i=1 -> grant order 0,1,2,3,0,1 with one result per cycle.
REQ-037 SHALL cover backpressure: res_ready_i=0 for 6 cycles with requesters busy -> exactly 2 operations accepted, then all req_ready_o low; after release every result is delivered once, in order.
REQ-038 SHALL cover reset mid-operation: rst_i pulsed while S1 and S2 are full -> next cycle res_valid_o=0 and busy_o=0, and the next grant goes to requester 0 when all are valid.
